mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, maximum number of BUSY cycles without mem_ready before an access is aborted; range 1..255; used only with MEM_TIMEOUT_EN.
REQ-002 clock  input  1  single clock; all state is updated on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 alu_in  input  32  ALU result from EX/MEM: the memory address for loads and stores, the writeback value otherwise.
REQ-005 rt_in  input  32  store data from EX/MEM.
REQ-006 dst_in  input  5  destination register number.
REQ-007 reg_write_in  input  1  instruction writes the register file.
REQ-008 mem_reg_dst_in  input  1  load: the writeback value is taken from memory.
REQ-009 mem_write_in  input  1  store.
REQ-010 stall  output  1  combinational; while high, the upstream EX/MEM register holds its contents.
REQ-011 mem_req, mem_we  output  1 each  registered data-memory request and write enable.
REQ-012 mem_addr, mem_wdata  output  32 each  registered address and store data.
REQ-013 mem_rdata  input  32  read data; valid when mem_ready is high.
REQ-014 mem_ready  input  1  memory completion, sampled only in BUSY.
REQ-015 wb_data  output  32  registered writeback value.
REQ-016 wb_dst  output  5  registered writeback register number.
REQ-017 wb_reg_write  output  1  registered writeback enable.
REQ-018 bus_error  output  1  sticky timeout flag.

Function
REQ-019 The block SHALL implement two states: IDLE and BUSY.
REQ-020 A memory op SHALL be mem_reg_dst_in | mem_write_in.
REQ-021 stall SHALL equal (IDLE & memory op) | (BUSY & ~mem_ready & ~timeout_hit).
REQ-022 IDLE, non-memory op, per edge: wb_data<=alu_in; wb_dst<=dst_in; wb_reg_write<=reg_write_in & (dst_in!=0); latency 1 cycle, no stall.
REQ-023 IDLE, memory op, per edge: mem_req<=1; mem_we<=mem_write_in; mem_addr<=alu_in; mem_wdata<=rt_in; wb_reg_write<=0 (bubble); state->BUSY.
REQ-024 BUSY with mem_ready=0: the block SHALL hold all mem_* outputs and keep wb_reg_write=0.
REQ-025 BUSY with mem_ready=1, per edge: mem_req<=0; mem_we<=0; state->IDLE; wb_dst<=dst_in.
REQ-026 On completion of a load, wb_data<=mem_rdata and wb_reg_write<=reg_write_in & (dst_in!=0).
REQ-027 On completion of a store, wb_reg_write<=0, mem_rdata SHALL be ignored, and wb_data SHALL hold its value.
REQ-028 Minimum memory-op latency SHALL be 2 cycles (mem_ready high in the first BUSY cycle); an access SHALL NOT be issued in the completion cycle.
REQ-029 An instruction with mem_reg_dst_in=mem_write_in=1 SHALL be treated as a store.
REQ-030 mem_ready in IDLE SHALL be ignored.
REQ-031 Writes to register 0 SHALL never assert wb_reg_write.

Reset
REQ-032 Asserting reset SHALL immediately, without a clock edge, force state=IDLE, clear the timeout counter, and set mem_req, mem_we, mem_addr, mem_wdata, wb_data, wb_dst, wb_reg_write and bus_error to 0.
REQ-033 Reset asserted mid-access (BUSY) SHALL abandon the access; a mem_ready arriving after reset has no effect.

Configuration
REQ-034 With MEM_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to BUSY and increment on each BUSY cycle with mem_ready=0; timeout_hit = (count==TIMEOUT_CYCLES-1) & ~mem_ready; on that edge the block SHALL set mem_req<=0, mem_we<=0, wb_reg_write<=0, bus_error<=1 (sticky until reset) and state->IDLE, and the instruction is dropped.
REQ-035 Without MEM_TIMEOUT_EN: the block SHALL contain no counter, timeout_hit=0, bus_error is tied to 0, and BUSY waits indefinitely.

Verification
REQ-036 Non-memory op: alu_in=0x00000010, dst_in=5, reg_write_in=1 -> next edge wb_data=0x10, wb_dst=5, wb_reg_write=1, stall stays 0.
REQ-037 Load: alu_in=0x100, mem_ready high 3 cycles after mem_req, mem_rdata=0xDEADBEEF -> stall high 4 cycles; wb_data=0xDEADBEEF, wb_reg_write=1 one edge after mem_ready.
REQ-038 Store: alu_in=0x40, rt_in=0x1234, mem_ready=1 in the first BUSY cycle -> mem_we=1, mem_addr=0x40, mem_wdata=0x1234 for one cycle; wb_reg_write stays 0.
REQ-039 Back-to-back loads to dst 3 then dst 0 -> each issues separately; the second completes with wb_reg_write=0.
REQ-040 MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, mem_ready held 0 -> abort after 4 BUSY cycles, bus_error=1, state IDLE; reset asserted mid-BUSY clears mem_req with no clock edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: issues loads/stores, waits on mem_ready, registers writeback.
// Define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES busy cycles.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] alu_in,
  input  logic [31:0] rt_in,
  input  logic [4:0]  dst_in,
  input  logic        reg_write_in,
  input  logic        mem_reg_dst_in,
  input  logic        mem_write_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dst,
  output logic        wb_reg_write,
  output logic        bus_error
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_dst_q, wb_dst_d;
  logic        wb_rw_q, wb_rw_d;

  logic mem_op, is_load, wr_ok, timeout_hit;

  // Both flags set counts as a store.
  assign mem_op  = mem_reg_dst_in | mem_write_in;
  assign is_load = mem_reg_dst_in & ~mem_write_in;
  assign wr_ok   = reg_write_in & (dst_in != 5'd0);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       berr_q, berr_d;

  assign timeout_hit = (state_q == BUSY) & (cnt_q == TO_LAST)
                     & ~mem_ready;

  always_comb begin
    cnt_d  = cnt_q;
    berr_d = berr_q | timeout_hit;
    if (state_q == IDLE)
      cnt_d = 8'd0;
    else if (!mem_ready)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= 8'd0;
      berr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      berr_q <= berr_d;
    end
  end

  assign bus_error = berr_q;
`else
  logic [7:0] unused_to;
  assign unused_to   = TO_LAST;
  assign timeout_hit = 1'b0;
  assign bus_error   = 1'b0;
`endif

  assign stall = ((state_q == IDLE) & mem_op)
               | ((state_q == BUSY) & ~mem_ready & ~timeout_hit);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_data_d   = wb_data_q;
    wb_dst_d    = wb_dst_q;
    wb_rw_d     = wb_rw_q;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          mem_req_d   = 1'b1;
          mem_we_d    = mem_write_in;
          mem_addr_d  = alu_in;
          mem_wdata_d = rt_in;
          wb_rw_d     = 1'b0;
          state_d     = BUSY;
        end else begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wb_data_d = alu_in;
          wb_dst_d  = dst_in;
          wb_rw_d   = wr_ok;
        end
      end
      BUSY: begin
        wb_rw_d = 1'b0;
        if (mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wb_dst_d  = dst_in;
          state_d   = IDLE;
          if (is_load) begin
            wb_data_d = mem_rdata;
            wb_rw_d   = wr_ok;
          end
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      wb_data_q   <= 32'd0;
      wb_dst_q    <= 5'd0;
      wb_rw_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_data_q   <= wb_data_d;
      wb_dst_q    <= wb_dst_d;
      wb_rw_q     <= wb_rw_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_data      = wb_data_q;
  assign wb_dst       = wb_dst_q;
  assign wb_reg_write = wb_rw_q;

endmodule
